resp_fifo_sched: RTL
====================

Name: resp_fifo_sched

Overview:
- Response scheduler in the REF_CLK domain. It takes system-controller result traffic (RegFile read data and 16-bit ALU results), buffers one response per source, and serialises it byte-wise into the async FIFO write port toward UART TX.
- It shares the single FIFO write port between the two requesters, using round-robin arbitration and honouring FIFO_FULL backpressure.

Parameters:
- DATA_WIDTH, 8, byte width of the FIFO and RegFile data; the ALU result is 2*DATA_WIDTH.

Ports:
- REF_CLK  input  1  system reference clock; all logic on its rising edge.
- RST  input  1  asynchronous reset, active-high.
- REGFILE_RdData  input  DATA_WIDTH  RegFile read data.
- REGFILE_RdData_VLD  input  1  one-cycle strobe: REGFILE_RdData is valid.
- ALU_OUT  input  2*DATA_WIDTH  ALU result.
- ALU_OUT_VLD  input  1  one-cycle strobe: ALU_OUT is valid.
- FIFO_FULL  input  1  FIFO write-side full, already synchronised to REF_CLK.
- FIFO_P_DATA  output  DATA_WIDTH  byte to the FIFO.
- FIFO_WR_INC  output  1  FIFO write strobe; a byte is written on each cycle it is high.
- REG_PEND  output  1  RegFile holding slot occupied.
- ALU_PEND  output  1  ALU holding slot occupied.
- REG_OVF  output  1  sticky: a RegFile response was dropped.
- ALU_OVF  output  1  sticky: an ALU response was dropped.

Behaviour:
- Holding slots, one per source: reg_hold[DATA_WIDTH-1:0] and alu_hold[2*DATA_WIDTH-1:0], each with a pend flag.
- A slot loads on the rising edge where its VLD is high and the slot is free.
  - A slot also counts as free in the cycle its last byte is written. Load wins, and pend stays 1 with the new data.
- VLD while a slot is occupied and not completing: the data is dropped and the matching *_OVF is set. It clears only on RST.
- FSM states:
  - IDLE: picks a source from the registered pend flags.
    - Only one pending: go to SEND_REG or SEND_ALU_LO.
    - Both pending: grant the source not granted last. The last-grant flop resets to ALU, so RegFile wins the first tie.
  - SEND_REG: drives reg_hold. On write, clear reg pend and go to IDLE.
  - SEND_ALU_LO: drives alu_hold[7:0]. On write, go to SEND_ALU_HI.
  - SEND_ALU_HI: drives alu_hold[15:8]. On write, clear alu pend and go to IDLE.
- Write rule: FIFO_WR_INC = (state is SEND_*) && !FIFO_FULL, combinational, so no registered overshoot of FULL is possible. FIFO_P_DATA is a combinational mux of the current byte and is 0 in IDLE.
- FIFO_FULL high in a SEND state: hold the state and data, with FIFO_WR_INC low. Resume on the first cycle FULL is low. There is no timeout.
- Latency with the FIFO not full: VLD in cycle 0, pend set at the end of cycle 0, IDLE decides in cycle 1, FIFO_WR_INC high in cycle 2.
  - RegFile: one write.
  - ALU: writes in cycles 2 and 3 (low byte, then high byte).
- Minimum gap: IDLE is always visited between responses, so back-to-back responses have one idle cycle between them.
- VLD for both sources in the same cycle: both load, and the tie is arbitrated next cycle.
- RST at any time: FSM to IDLE, both pend=0, both OVF=0, last-grant=ALU, FIFO_WR_INC=0, FIFO_P_DATA=0. A response partially written to the FIFO (ALU low byte only) is abandoned; this is acceptable because the FIFO is reset alongside.

Optional Feature:
- Macro: RESP_SCHED_FRAME_TAG_EN.
- Defined: each response is prefixed with a tag byte via state SEND_TAG, entered from IDLE on grant.
  - Tags: 8'hA5 for RegFile, 8'h5A for ALU.
  - SEND_TAG obeys the same FULL stall rule.
  - Latency of the data bytes grows by one cycle: RegFile is 2 writes, ALU is 3.
- Undefined: no SEND_TAG state and no tag bytes; behaviour is exactly as above.

Decomposition:
- Shared package holds:
  - the state enum e_resp_states {IDLE, SEND_TAG, SEND_REG, SEND_ALU_LO, SEND_ALU_HI} in 3 bits, with SEND_TAG always declared;
  - the tag constants RESP_TAG_REG=8'hA5 and RESP_TAG_ALU=8'h5A;
  - the grant encoding constants GNT_REG=1'b0 and GNT_ALU=1'b1.
- One natural sub-module: resp_hold_slot, parameterised width, containing the load/pend/overflow logic. It is instantiated twice (8-bit and 16-bit).

Test Plan:
- REGFILE_RdData=8'h3C with VLD in cycle 0, FIFO not full -> FIFO_WR_INC high only in cycle 2 with FIFO_P_DATA=8'h3C; REG_PEND falls after cycle 2.
- ALU_OUT=16'hBEEF VLD, FULL low -> writes 8'hEF then 8'hBE on consecutive cycles; no third write.
- Both VLD in the same cycle (RegFile 8'h11, ALU 16'h2233) just after reset -> write order 11, 33, 22. A second simultaneous pair -> ALU first (33, 22), then 11.
- ALU 16'h1234 with FIFO_FULL forced high from the first SEND cycle for 5 cycles -> no write while FULL; then 34, 12; the data is never corrupted.
- A second ALU_OUT_VLD (16'h9999) while 16'h1234 is stalled -> ALU_OVF=1 and stays 1; only 34, 12 are written; a later RST clears ALU_OVF.
- RST asserted between the LO and HI ALU writes -> FIFO_WR_INC=0 immediately, FSM IDLE, pend/OVF cleared; with RESP_SCHED_FRAME_TAG_EN defined, a RegFile 8'h3C yields A5, 3C.

Source files
------------

// File: rtl/resp_fifo_sched_pkg.sv
// Shared types and constants for the response scheduler.
// RESP_SCHED_FRAME_TAG_EN adds a tag byte ahead of every response.
package resp_fifo_sched_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SEND_TAG    = 3'd1,
        SEND_REG    = 3'd2,
        SEND_ALU_LO = 3'd3,
        SEND_ALU_HI = 3'd4
    } e_resp_states;

    localparam logic [7:0] RESP_TAG_REG = 8'hA5;
    localparam logic [7:0] RESP_TAG_ALU = 8'h5A;

    localparam logic GNT_REG = 1'b0;
    localparam logic GNT_ALU = 1'b1;

endpackage

// File: rtl/resp_hold_slot.sv
// One-response holding slot with pending flag and sticky overflow.
// A completing slot is free again in the same cycle.
module resp_hold_slot
    import resp_fifo_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic [WIDTH-1:0] data,
    input  logic             done,
    output logic [WIDTH-1:0] hold,
    output logic             pend,
    output logic             ovf
);

    logic free;

    assign free = !pend || done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            pend <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (vld && free) begin
                hold <= data;
                pend <= 1'b1;
            end else if (done) begin
                pend <= 1'b0;
            end
            if (vld && !free) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/resp_fifo_sched.sv
// Round-robin byte serialiser of RegFile/ALU responses into a FIFO.
// RESP_SCHED_FRAME_TAG_EN prefixes each response with a tag byte.
module resp_fifo_sched
    import resp_fifo_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    REF_CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   REGFILE_RdData,
    input  logic                    REGFILE_RdData_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic [DATA_WIDTH-1:0]   FIFO_P_DATA,
    output logic                    FIFO_WR_INC,
    output logic                    REG_PEND,
    output logic                    ALU_PEND,
    output logic                    REG_OVF,
    output logic                    ALU_OVF
);

    e_resp_states state, state_nxt;

    logic last_gnt, gnt_nxt;
    logic src, src_nxt;
    logic pick;
    logic wr;
    logic reg_done, alu_done;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] reg_hold;
    logic [2*DATA_WIDTH-1:0] alu_hold;

    assign reg_done = wr && (state == SEND_REG);
    assign alu_done = wr && (state == SEND_ALU_HI);

    resp_hold_slot #(.WIDTH(DATA_WIDTH)) u_reg_slot (
        .clk  (REF_CLK),
        .rst  (RST),
        .vld  (REGFILE_RdData_VLD),
        .data (REGFILE_RdData),
        .done (reg_done),
        .hold (reg_hold),
        .pend (REG_PEND),
        .ovf  (REG_OVF)
    );

    resp_hold_slot #(.WIDTH(2*DATA_WIDTH)) u_alu_slot (
        .clk  (REF_CLK),
        .rst  (RST),
        .vld  (ALU_OUT_VLD),
        .data (ALU_OUT),
        .done (alu_done),
        .hold (alu_hold),
        .pend (ALU_PEND),
        .ovf  (ALU_OVF)
    );

    always_ff @(posedge REF_CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            last_gnt <= GNT_ALU;
            src      <= GNT_REG;
        end else begin
            state    <= state_nxt;
            last_gnt <= gnt_nxt;
            src      <= src_nxt;
        end
    end

    // last_gnt only moves on contended decisions; src follows every grant
    always_comb begin
        state_nxt = state;
        gnt_nxt   = last_gnt;
        src_nxt   = src;
        pick      = GNT_REG;
        wr        = 1'b0;
        data      = '0;
        unique case (state)
            IDLE: begin
                if (REG_PEND && ALU_PEND) begin
                    pick    = (last_gnt == GNT_ALU) ? GNT_REG : GNT_ALU;
                    gnt_nxt = pick;
                end else begin
                    pick = ALU_PEND ? GNT_ALU : GNT_REG;
                end
                if (REG_PEND || ALU_PEND) begin
                    src_nxt = pick;
`ifdef RESP_SCHED_FRAME_TAG_EN
                    state_nxt = SEND_TAG;
`else
                    state_nxt = (pick == GNT_REG) ? SEND_REG : SEND_ALU_LO;
`endif
                end
            end
            SEND_TAG: begin
                data = (src == GNT_REG) ? DATA_WIDTH'(RESP_TAG_REG)
                                        : DATA_WIDTH'(RESP_TAG_ALU);
                wr   = !FIFO_FULL;
                if (wr) begin
                    state_nxt = (src == GNT_REG) ? SEND_REG : SEND_ALU_LO;
                end
            end
            SEND_REG: begin
                data = reg_hold;
                wr   = !FIFO_FULL;
                if (wr) begin
                    state_nxt = IDLE;
                end
            end
            SEND_ALU_LO: begin
                data = alu_hold[DATA_WIDTH-1:0];
                wr   = !FIFO_FULL;
                if (wr) begin
                    state_nxt = SEND_ALU_HI;
                end
            end
            SEND_ALU_HI: begin
                data = alu_hold[2*DATA_WIDTH-1:DATA_WIDTH];
                wr   = !FIFO_FULL;
                if (wr) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign FIFO_WR_INC = wr;
    assign FIFO_P_DATA = data;

endmodule
